// File: rtl/rv_decode_stage_if.sv
// Fetch-to-execute handshake and decoded-field bundle around rv_decode_stage.
// master drives fetch/execute controls; slave is the decode stage itself.
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [9:0]      ctrl;
  logic [XLEN-1:0] imm;
  logic            imm_en;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            rd_we;
  logic            is_load;
  logic            is_store;
  logic            is_branch;
  logic            is_jump;
  logic            use_pc;
  logic            illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, ctrl, imm, imm_en, rs1, rs2, rd, rd_we,
           is_load, is_store, is_branch, is_jump, use_pc, illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, ctrl, imm, imm_en, rs1, rs2, rd, rd_we,
           is_load, is_store, is_branch, is_jump, use_pc, illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: one pipeline register with stall and flush.
// Optional macro DEC_SHAMT_CHECK_EN makes malformed OP-IMM shift encodings illegal.
module rv_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit RESET_NOP = 1'b1
) (
  input logic               clk,
  input logic               rst,
  rv_decode_stage_if.slave  dec
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [9:0] CTRL_ADD  = 10'h000;
  localparam logic [9:0] CTRL_SUB  = 10'h100;
  localparam logic [9:0] CTRL_SLT  = 10'h002;
  localparam logic [9:0] CTRL_SLTU = 10'h003;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'h000};
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [9:0]      ctrl_s;
  logic [XLEN-1:0] imm_s_s;
  logic            imm_en_s;
  logic [4:0]      rs1_s;
  logic            rd_we_s;
  logic            is_load_s;
  logic            is_store_s;
  logic            is_branch_s;
  logic            is_jump_s;
  logic            use_pc_s;
  logic            illegal_s;
  logic            capture_s;

  logic            out_valid_r;
  logic [9:0]      ctrl_r;
  logic [XLEN-1:0] imm_r;
  logic            imm_en_r;
  logic [4:0]      rs1_r;
  logic [4:0]      rs2_r;
  logic [4:0]      rd_r;
  logic            rd_we_r;
  logic            is_load_r;
  logic            is_store_r;
  logic            is_branch_r;
  logic            is_jump_r;
  logic            use_pc_r;
  logic            illegal_r;

  assign opcode_s  = dec.instr[6:0];
  assign funct3_s  = dec.instr[14:12];
  assign funct7_s  = dec.instr[31:25];
  assign dec.in_ready = !dec.flush && (!out_valid_r || dec.out_ready);
  assign capture_s = dec.in_valid && dec.in_ready;

  // Combinational decode of the presented instruction word.
  always_comb begin
    ctrl_s      = CTRL_ADD;
    imm_s_s     = {XLEN{1'b0}};
    imm_en_s    = 1'b0;
    rs1_s       = dec.instr[19:15];
    rd_we_s     = 1'b0;
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    is_jump_s   = 1'b0;
    use_pc_s    = 1'b0;
    illegal_s   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        ctrl_s  = {funct7_s, funct3_s};
        rd_we_s = 1'b1;
        if (funct7_s == 7'b0000000) begin
          illegal_s = 1'b0;
        end else if (funct7_s == 7'b0100000 && (funct3_s == 3'b000 || funct3_s == 3'b101)) begin
          illegal_s = 1'b0;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        imm_s_s  = imm_i(dec.instr);
        imm_en_s = 1'b1;
        rd_we_s  = 1'b1;
        if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
          ctrl_s = {1'b0, dec.instr[30], 5'b00000, funct3_s};
`ifdef DEC_SHAMT_CHECK_EN
          illegal_s = (funct3_s == 3'b001 && dec.instr[30]) || dec.instr[25] ||
                      dec.instr[31] || (dec.instr[29:26] != 4'b0000);
`else
          illegal_s = (funct3_s == 3'b001) && dec.instr[30];
`endif
        end else begin
          ctrl_s = {7'b0000000, funct3_s};
        end
      end
      OPC_LUI: begin
        imm_s_s  = imm_u(dec.instr);
        imm_en_s = 1'b1;
        rd_we_s  = 1'b1;
        rs1_s    = 5'd0;
      end
      OPC_AUIPC: begin
        imm_s_s  = imm_u(dec.instr);
        imm_en_s = 1'b1;
        rd_we_s  = 1'b1;
        use_pc_s = 1'b1;
      end
      OPC_LOAD: begin
        imm_s_s   = imm_i(dec.instr);
        imm_en_s  = 1'b1;
        rd_we_s   = 1'b1;
        is_load_s = 1'b1;
      end
      OPC_STORE: begin
        imm_s_s    = imm_s(dec.instr);
        imm_en_s   = 1'b1;
        is_store_s = 1'b1;
      end
      OPC_BRANCH: begin
        imm_s_s     = imm_b(dec.instr);
        is_branch_s = 1'b1;
        case (funct3_s)
          3'b000, 3'b001: ctrl_s = CTRL_SUB;
          3'b100, 3'b101: ctrl_s = CTRL_SLT;
          3'b110, 3'b111: ctrl_s = CTRL_SLTU;
          default:        illegal_s = 1'b1;
        endcase
      end
      OPC_JAL: begin
        imm_s_s   = imm_j(dec.instr);
        imm_en_s  = 1'b1;
        rd_we_s   = 1'b1;
        is_jump_s = 1'b1;
        use_pc_s  = 1'b1;
      end
      OPC_JALR: begin
        imm_s_s   = imm_i(dec.instr);
        imm_en_s  = 1'b1;
        rd_we_s   = 1'b1;
        is_jump_s = 1'b1;
        if (funct3_s != 3'b000) begin
          illegal_s = 1'b1;
        end else begin
          illegal_s = 1'b0;
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Pipeline register: flush beats capture, capture beats drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      ctrl_r      <= 10'h000;
      imm_r       <= {XLEN{1'b0}};
      imm_en_r    <= RESET_NOP ? 1'b1 : 1'b0;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      rd_r        <= 5'd0;
      rd_we_r     <= 1'b0;
      is_load_r   <= 1'b0;
      is_store_r  <= 1'b0;
      is_branch_r <= 1'b0;
      is_jump_r   <= 1'b0;
      use_pc_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (dec.flush) begin
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      ctrl_r      <= ctrl_s;
      imm_r       <= imm_s_s;
      imm_en_r    <= imm_en_s;
      rs1_r       <= rs1_s;
      rs2_r       <= dec.instr[24:20];
      rd_r        <= dec.instr[11:7];
      // An illegal word still reaches execute, but must not side-effect.
      rd_we_r     <= rd_we_s     & ~illegal_s;
      is_load_r   <= is_load_s   & ~illegal_s;
      is_store_r  <= is_store_s  & ~illegal_s;
      is_branch_r <= is_branch_s & ~illegal_s;
      is_jump_r   <= is_jump_s   & ~illegal_s;
      use_pc_r    <= use_pc_s;
      illegal_r   <= illegal_s;
    end else if (out_valid_r && dec.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign dec.out_valid = out_valid_r;
  assign dec.ctrl      = ctrl_r;
  assign dec.imm       = imm_r;
  assign dec.imm_en    = imm_en_r;
  assign dec.rs1       = rs1_r;
  assign dec.rs2       = rs2_r;
  assign dec.rd        = rd_r;
  assign dec.rd_we     = rd_we_r;
  assign dec.is_load   = is_load_r;
  assign dec.is_store  = is_store_r;
  assign dec.is_branch = is_branch_r;
  assign dec.is_jump   = is_jump_r;
  assign dec.use_pc    = use_pc_r;
  assign dec.illegal   = illegal_r;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage (default RESET_NOP=1).
module tb_rv_decode_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rv_decode_stage_if dif ();

  rv_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .dec (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  ctrl;
    logic [31:0] imm;
    logic [7:0]  flags;  // imm_en, rd_we, load, store, branch, jump, use_pc, illegal
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [0:13];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.in_valid = 1'b0;
    dif.instr = 32'h0000_0000;
    dif.flush = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({dif.out_valid, dif.ctrl, dif.imm, dif.imm_en, dif.rs1, dif.rs2, dif.rd} !==
        {1'b0, 10'h000, 32'h0000_0000, 1'b1, 5'd0, 5'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_fields: got v=%b ctrl=%h imm=%h imm_en=%b rs1=%0d rs2=%0d rd=%0d, want v=0 ctrl=000 imm=0 imm_en=1 regs=0",
               dif.out_valid, dif.ctrl, dif.imm, dif.imm_en, dif.rs1, dif.rs2, dif.rd);
    end
    checks++;
    if ({dif.rd_we, dif.is_load, dif.is_store, dif.is_branch, dif.is_jump, dif.use_pc, dif.illegal} !== 7'b0000000) begin
      failures++;
      $display("FAIL reset_flags: got %b, want 0000000",
               {dif.rd_we, dif.is_load, dif.is_store, dif.is_branch, dif.is_jump, dif.use_pc, dif.illegal});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, want 1", dif.in_ready);
    end
  endtask

  task automatic test_add;
    dif.out_ready = 1'b1;
    dif.in_valid = 1'b1;
    dif.instr = 32'h0020_81B3;
    tick();
    dif.in_valid = 1'b0;
    checks++;
    if ({dif.out_valid, dif.ctrl, dif.rs1, dif.rs2, dif.rd, dif.imm_en, dif.rd_we, dif.illegal} !==
        {1'b1, 10'h000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add: got v=%b ctrl=%h rs1=%0d rs2=%0d rd=%0d imm_en=%b rd_we=%b ill=%b, want 1 000 1 2 3 0 1 0",
               dif.out_valid, dif.ctrl, dif.rs1, dif.rs2, dif.rd, dif.imm_en, dif.rd_we, dif.illegal);
    end
    tick();
    checks++;
    if (dif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_drain: out_valid got %b, want 0", dif.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    dif.out_ready = 1'b1;
    dif.in_valid = 1'b1;
    dif.instr = 32'h4073_02B3;
    tick();
    checks++;
    if ({dif.out_valid, dif.ctrl, dif.imm_en, dif.rd} !== {1'b1, 10'h100, 1'b0, 5'd5}) begin
      failures++;
      $display("FAIL b2b_sub: got v=%b ctrl=%h imm_en=%b rd=%0d, want 1 100 0 5",
               dif.out_valid, dif.ctrl, dif.imm_en, dif.rd);
    end
    dif.instr = 32'h4031_5113;
    tick();
    dif.in_valid = 1'b0;
    checks++;
    if ({dif.out_valid, dif.ctrl, dif.imm[4:0], dif.imm_en, dif.rd, dif.illegal} !==
        {1'b1, 10'h105, 5'd3, 1'b1, 5'd2, 1'b0}) begin
      failures++;
      $display("FAIL b2b_srai: got v=%b ctrl=%h imm4=%0d imm_en=%b rd=%0d ill=%b, want 1 105 3 1 2 0",
               dif.out_valid, dif.ctrl, dif.imm[4:0], dif.imm_en, dif.rd, dif.illegal);
    end
    tick();
  endtask

  task automatic test_stall;
    dif.out_ready = 1'b0;
    dif.in_valid = 1'b1;
    dif.instr = 32'hFFF0_0093;
    tick();
    dif.instr = 32'h0020_81B3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dif.in_ready, dif.out_valid, dif.imm, dif.rd, dif.ctrl, dif.imm_en} !==
          {1'b0, 1'b1, 32'hFFFF_FFFF, 5'd1, 10'h000, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b imm=%h rd=%0d ctrl=%h imm_en=%b, want 0 1 ffffffff 1 000 1",
                 i, dif.in_ready, dif.out_valid, dif.imm, dif.rd, dif.ctrl, dif.imm_en);
      end
      tick();
    end
    dif.out_ready = 1'b1;
    #1;
    checks++;
    if (dif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %b, want 1", dif.in_ready);
    end
    tick();
    dif.in_valid = 1'b0;
    checks++;
    if ({dif.out_valid, dif.rd, dif.imm_en, dif.rs2} !== {1'b1, 5'd3, 1'b0, 5'd2}) begin
      failures++;
      $display("FAIL stall_next_capture: got v=%b rd=%0d imm_en=%b rs2=%0d, want 1 3 0 2",
               dif.out_valid, dif.rd, dif.imm_en, dif.rs2);
    end
    tick();
  endtask

  task automatic test_flush;
    dif.out_ready = 1'b1;
    dif.in_valid = 1'b1;
    dif.instr = 32'h0000_0000;
    dif.flush = 1'b1;
    #1;
    checks++;
    if (dif.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready: got %b, want 0", dif.in_ready);
    end
    tick();
    checks++;
    if (dif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_block: out_valid got %b, want 0", dif.out_valid);
    end
    dif.flush = 1'b0;
    tick();
    dif.in_valid = 1'b0;
    checks++;
    if ({dif.out_valid, dif.illegal, dif.rd_we} !== {1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flush_then_zero: got v=%b ill=%b rd_we=%b, want 1 1 0",
               dif.out_valid, dif.illegal, dif.rd_we);
    end
    // Flush also kills an instruction being held under backpressure.
    dif.out_ready = 1'b0;
    dif.in_valid = 1'b1;
    dif.instr = 32'h0020_81B3;
    tick();
    dif.in_valid = 1'b0;
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    checks++;
    if (dif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_held: out_valid got %b, want 0", dif.out_valid);
    end
    dif.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_shamt;
    dif.out_ready = 1'b1;
    dif.in_valid = 1'b1;
    dif.instr = 32'h0200_9093;
    tick();
    dif.in_valid = 1'b0;
    checks++;
`ifdef DEC_SHAMT_CHECK_EN
    if ({dif.out_valid, dif.illegal, dif.rd_we, dif.ctrl} !== {1'b1, 1'b1, 1'b0, 10'h001}) begin
      failures++;
      $display("FAIL shamt_check: got v=%b ill=%b rd_we=%b ctrl=%h, want 1 1 0 001",
               dif.out_valid, dif.illegal, dif.rd_we, dif.ctrl);
    end
`else
    if ({dif.out_valid, dif.illegal, dif.rd_we, dif.ctrl} !== {1'b1, 1'b0, 1'b1, 10'h001}) begin
      failures++;
      $display("FAIL shamt_nocheck: got v=%b ill=%b rd_we=%b ctrl=%h, want 1 0 1 001",
               dif.out_valid, dif.illegal, dif.rd_we, dif.ctrl);
    end
`endif
    tick();
  endtask

  task automatic test_decode_table;
    logic [7:0] flags_obs;
    vecs[0]  = '{32'h0081_2283, 10'h000, 32'h0000_0008, 8'b1110_0000, 5'd2, 5'd8, 5'd5};
    vecs[1]  = '{32'hFE60_AE23, 10'h000, 32'hFFFF_FFFC, 8'b1001_0000, 5'd1, 5'd6, 5'd28};
    vecs[2]  = '{32'h0020_8863, 10'h100, 32'h0000_0010, 8'b0000_1000, 5'd1, 5'd2, 5'd16};
    vecs[3]  = '{32'hFE41_ECE3, 10'h003, 32'hFFFF_FFF8, 8'b0000_1000, 5'd3, 5'd4, 5'd25};
    vecs[4]  = '{32'h0010_00EF, 10'h000, 32'h0000_0800, 8'b1100_0110, 5'd0, 5'd1, 5'd1};
    vecs[5]  = '{32'h0000_8067, 10'h000, 32'h0000_0000, 8'b1100_0100, 5'd1, 5'd0, 5'd0};
    vecs[6]  = '{32'h0000_9067, 10'h000, 32'h0000_0000, 8'b1000_0001, 5'd1, 5'd0, 5'd0};
    vecs[7]  = '{32'h1234_53B7, 10'h000, 32'h1234_5000, 8'b1100_0000, 5'd0, 5'd3, 5'd7};
    vecs[8]  = '{32'h1234_5397, 10'h000, 32'h1234_5000, 8'b1100_0010, 5'd8, 5'd3, 5'd7};
    vecs[9]  = '{32'h0231_00B3, 10'h008, 32'h0000_0000, 8'b0000_0001, 5'd2, 5'd3, 5'd1};
    vecs[10] = '{32'h0020_A863, 10'h000, 32'h0000_0010, 8'b0000_0001, 5'd1, 5'd2, 5'd16};
    vecs[11] = '{32'h4020_90B3, 10'h101, 32'h0000_0000, 8'b0000_0001, 5'd1, 5'd2, 5'd1};
    vecs[12] = '{32'hFFF2_C213, 10'h004, 32'hFFFF_FFFF, 8'b1100_0000, 5'd5, 5'd31, 5'd4};
    vecs[13] = '{32'h4020_9093, 10'h101, 32'h0000_0402, 8'b1000_0001, 5'd1, 5'd2, 5'd1};
    dif.out_ready = 1'b1;
    dif.in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      dif.instr = vecs[i].instr;
      tick();
      flags_obs = {dif.imm_en, dif.rd_we, dif.is_load, dif.is_store,
                   dif.is_branch, dif.is_jump, dif.use_pc, dif.illegal};
      checks++;
      if ({dif.out_valid, dif.ctrl, dif.imm, flags_obs, dif.rs1, dif.rs2, dif.rd} !==
          {1'b1, vecs[i].ctrl, vecs[i].imm, vecs[i].flags, vecs[i].rs1, vecs[i].rs2, vecs[i].rd}) begin
        failures++;
        $display("FAIL decode[%0d] instr=%h: got v=%b ctrl=%h imm=%h flags=%b rs1=%0d rs2=%0d rd=%0d, want v=1 ctrl=%h imm=%h flags=%b rs1=%0d rs2=%0d rd=%0d",
                 i, vecs[i].instr, dif.out_valid, dif.ctrl, dif.imm, flags_obs, dif.rs1, dif.rs2, dif.rd,
                 vecs[i].ctrl, vecs[i].imm, vecs[i].flags, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      end
    end
    dif.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream;
    dif.out_ready = 1'b0;
    dif.in_valid = 1'b1;
    dif.instr = 32'h0020_81B3;
    tick();
    dif.in_valid = 1'b0;
    checks++;
    if ({dif.out_valid, dif.rd, dif.imm_en} !== {1'b1, 5'd3, 1'b0}) begin
      failures++;
      $display("FAIL midreset_pre: got v=%b rd=%0d imm_en=%b, want 1 3 0",
               dif.out_valid, dif.rd, dif.imm_en);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dif.out_valid, dif.ctrl, dif.imm, dif.imm_en, dif.rs1, dif.rs2, dif.rd, dif.rd_we, dif.illegal} !==
        {1'b0, 10'h000, 32'h0000_0000, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_async: got v=%b ctrl=%h imm=%h imm_en=%b rs1=%0d rs2=%0d rd=%0d rd_we=%b ill=%b, want 0 000 0 1 0 0 0 0 0",
               dif.out_valid, dif.ctrl, dif.imm, dif.imm_en, dif.rs1, dif.rs2, dif.rd, dif.rd_we, dif.illegal);
    end
    tick();
    rst = 1'b0;
    dif.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_flush();
    test_shamt();
    test_decode_table();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
